// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_arbiter: shared writeback arbiter for scalar and vector pipelines;      |
// | oldest-by-tag wins each RF port, losing vector results are parked in order.|
// | Optional performance counters: WB_PERF_CNT_EN                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int VDATA_W   = 128,
    parameter int BUF_DEPTH = 4,
    parameter int TAG_W     = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [TAG_W-1:0]           s_tag,
    input  logic                       s_rf_sel,
    input  logic [4:0]                 s_addr,
    input  logic [VDATA_W-1:0]         s_data,
    output logic                       s_stall,
    input  logic                       v_valid,
    input  logic [TAG_W-1:0]           v_tag,
    input  logic                       v_rf_sel,
    input  logic [4:0]                 v_addr,
    input  logic [VDATA_W-1:0]         v_data,
    output logic                       reg_wr_en,
    output logic [4:0]                 reg_wr_addr,
    output logic [DATA_W-1:0]          reg_wr_data,
    output logic                       vec_wr_en,
    output logic [4:0]                 vec_wr_addr,
    output logic [VDATA_W-1:0]         vec_wr_data,
    output logic [$clog2(BUF_DEPTH):0] buf_count,
    output logic                       buf_almost_full,
    output logic                       overflow,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_buf_cnt
);
    localparam int                 c_ptr_w = $clog2(BUF_DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(BUF_DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // a is older than b when b is 1 .. 2^(TAG_W-1)-1 steps ahead, modulo wrap
    function automatic logic f_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
        logic [TAG_W-1:0] d;
        d = b - a;
        return (d != '0) && !d[TAG_W-1];
    endfunction

    state_t               r_state, w_state_next;
    logic [c_ptr_w-1:0]   r_rd_ptr, r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count, w_count_next;
    logic                 r_overflow;
    logic [TAG_W-1:0]     r_buf_tag  [BUF_DEPTH];
    logic                 r_buf_sel  [BUF_DEPTH];
    logic [4:0]           r_buf_addr [BUF_DEPTH];
    logic [VDATA_W-1:0]   r_buf_data [BUF_DEPTH];

    logic                 w_h_valid, w_h_sel, w_h_grant;
    logic [TAG_W-1:0]     w_h_tag;
    logic [4:0]           w_h_addr;
    logic [VDATA_W-1:0]   w_h_data;
    logic                 w_v_direct_ok, w_v_grant, w_s_block, w_s_grant;
    logic                 w_push, w_pop, w_drop, w_push_ok;
    logic                 w_rw_en, w_vw_en;
    logic [4:0]           w_rw_addr, w_vw_addr;
    logic [DATA_W-1:0]    w_rw_data;
    logic [VDATA_W-1:0]   w_vw_data;

    assign w_h_valid = (r_state != ST_EMPTY);
    assign w_h_tag   = r_buf_tag[r_rd_ptr];
    assign w_h_sel   = r_buf_sel[r_rd_ptr];
    assign w_h_addr  = r_buf_addr[r_rd_ptr];
    assign w_h_data  = r_buf_data[r_rd_ptr];

    // The head only yields to a strictly older scalar result; ties favour vector work
    assign w_h_grant     = w_h_valid && !(s_valid && s_rf_sel == w_h_sel && f_older(s_tag, w_h_tag));
    assign w_v_direct_ok = !w_h_valid || (w_h_grant && r_count == c_one);
    assign w_v_grant     = v_valid && w_v_direct_ok
                           && !(w_h_grant && w_h_sel == v_rf_sel)
                           && !(s_valid && s_rf_sel == v_rf_sel && f_older(s_tag, v_tag));

    always_comb begin
        w_s_block = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (({1'b0, c_ptr_w'(i) - r_rd_ptr} < r_count)
                && r_buf_sel[i] == s_rf_sel && f_older(r_buf_tag[i], s_tag))
                w_s_block = 1'b1;
        end
        if (v_valid && !w_v_grant && v_rf_sel == s_rf_sel && f_older(v_tag, s_tag))
            w_s_block = 1'b1;
        if ((w_h_grant && w_h_sel == s_rf_sel) || (w_v_grant && v_rf_sel == s_rf_sel))
            w_s_block = 1'b1;
    end

    assign w_s_grant = s_valid && !w_s_block;
    assign s_stall   = s_valid && !w_s_grant;

    assign w_push    = v_valid && !w_v_grant;
    assign w_pop     = w_h_grant;
    assign w_drop    = w_push && (r_state == ST_FULL) && !w_pop;
    assign w_push_ok = w_push && !w_drop;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop)
            w_count_next = r_count + c_one;
        else if (!w_push_ok && w_pop)
            w_count_next = r_count - c_one;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_push_ok && !w_pop) w_state_next = ST_BUSY;
            ST_BUSY: begin
                if (w_count_next == '0)          w_state_next = ST_EMPTY;
                else if (w_count_next == c_depth) w_state_next = ST_FULL;
            end
            ST_FULL:  if (w_pop && !w_push_ok) w_state_next = ST_BUSY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_rw_en   = 1'b0;
        w_rw_addr = '0;
        w_rw_data = '0;
        if (w_h_grant && !w_h_sel) begin
            w_rw_en = 1'b1; w_rw_addr = w_h_addr; w_rw_data = w_h_data[DATA_W-1:0];
        end else if (w_v_grant && !v_rf_sel) begin
            w_rw_en = 1'b1; w_rw_addr = v_addr; w_rw_data = v_data[DATA_W-1:0];
        end else if (w_s_grant && !s_rf_sel) begin
            w_rw_en = 1'b1; w_rw_addr = s_addr; w_rw_data = s_data[DATA_W-1:0];
        end
    end

    always_comb begin
        w_vw_en   = 1'b0;
        w_vw_addr = '0;
        w_vw_data = '0;
        if (w_h_grant && w_h_sel) begin
            w_vw_en = 1'b1; w_vw_addr = w_h_addr; w_vw_data = w_h_data;
        end else if (w_v_grant && v_rf_sel) begin
            w_vw_en = 1'b1; w_vw_addr = v_addr; w_vw_data = v_data;
        end else if (w_s_grant && s_rf_sel) begin
            w_vw_en = 1'b1; w_vw_addr = s_addr; w_vw_data = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            vec_wr_en   <= 1'b0;
            vec_wr_addr <= '0;
            vec_wr_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_drop)    r_overflow <= 1'b1;
            reg_wr_en   <= w_rw_en;
            reg_wr_addr <= w_rw_addr;
            reg_wr_data <= w_rw_data;
            vec_wr_en   <= w_vw_en;
            vec_wr_addr <= w_vw_addr;
            vec_wr_data <= w_vw_data;
        end
    end

    // Storage is not reset: occupancy is tracked solely by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst) begin
            r_buf_tag[r_wr_ptr]  <= v_tag;
            r_buf_sel[r_wr_ptr]  <= v_rf_sel;
            r_buf_addr[r_wr_ptr] <= v_addr;
            r_buf_data[r_wr_ptr] <= v_data;
        end
    end

    assign buf_count       = r_count;
    assign buf_almost_full = (r_count >= c_depth - c_one);
    assign overflow        = r_overflow;

`ifdef WB_PERF_CNT_EN
    logic [31:0] r_perf_stall, r_perf_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_buf   <= '0;
        end else begin
            if (s_stall) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_push)  r_perf_buf   <= r_perf_buf + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_buf_cnt   = r_perf_buf;
`else
    assign perf_stall_cnt = '0;
    assign perf_buf_cnt   = '0;
`endif

endmodule
`default_nettype wire
